// File: rtl/energy_detect.sv
// Sums |x| over windows of 2^LOG2W samples and runs a hysteresis/hold detector on each window sum.
// energy updates 1 cycle after the last sample and detected 2 cycles after it; no backpressure, every x_valid sample is taken.
module energy_detect #(
  parameter int DW    = 16,
  parameter int LOG2W = 8,
  parameter logic [DW+LOG2W-1:0] TH_ON  = {{(DW+LOG2W-1){1'b0}}, 1'b1} << (DW+LOG2W-3),
  parameter logic [DW+LOG2W-1:0] TH_OFF = {{(DW+LOG2W-1){1'b0}}, 1'b1} << (DW+LOG2W-4),
  parameter int HOLD  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [DW-1:0]   x,
  input  logic                   x_valid,
  output logic [DW+LOG2W-1:0]    energy,
  output logic                   energy_valid,
  output logic                   detected
);

  localparam int         EW     = DW + LOG2W;
  localparam logic [3:0] HOLD_C = 4'(HOLD);

  typedef enum logic [1:0] {S_OFF, S_ARM, S_ON, S_DISARM} state_t;

  logic [DW-1:0]    w_abs;
  logic [EW-1:0]    w_sum;
  logic [EW-1:0]    r_acc;
  logic [LOG2W-1:0] r_cnt;
  logic [EW-1:0]    r_energy;
  logic             r_ev;
  state_t           r_state;
  logic [3:0]       r_hc;
  logic             r_det;

  // Negating the most negative sample wraps to 2^(DW-1), which is the correct unsigned magnitude.
  assign w_abs = x[DW-1] ? DW'(-x) : DW'(x);
  assign w_sum = r_acc + {{LOG2W{1'b0}}, w_abs};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_energy <= '0;
      r_ev     <= 1'b0;
    end else begin
      r_ev <= 1'b0;
      if (x_valid) begin
        if (r_cnt == {LOG2W{1'b1}}) begin
          r_energy <= w_sum;
          r_acc    <= '0;
          r_cnt    <= '0;
          r_ev     <= 1'b1;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // Decision only moves on the cycle a fresh window sum is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_OFF;
      r_hc    <= '0;
      r_det   <= 1'b0;
    end else if (r_ev) begin
      case (r_state)
        S_OFF: begin
          if (r_energy >= TH_ON) begin
            if (HOLD_C == 4'd1) begin
              r_state <= S_ON;
              r_det   <= 1'b1;
              r_hc    <= '0;
            end else begin
              r_state <= S_ARM;
              r_hc    <= 4'd1;
            end
          end
        end
        S_ARM: begin
          if (r_energy >= TH_ON) begin
            if (r_hc + 4'd1 == HOLD_C) begin
              r_state <= S_ON;
              r_det   <= 1'b1;
              r_hc    <= '0;
            end else begin
              r_hc <= r_hc + 4'd1;
            end
          end else begin
            r_state <= S_OFF;
            r_hc    <= '0;
          end
        end
        S_ON: begin
          if (r_energy < TH_OFF) begin
            if (HOLD_C == 4'd1) begin
              r_state <= S_OFF;
              r_det   <= 1'b0;
              r_hc    <= '0;
            end else begin
              r_state <= S_DISARM;
              r_hc    <= 4'd1;
            end
          end
        end
        S_DISARM: begin
          if (r_energy < TH_OFF) begin
            if (r_hc + 4'd1 == HOLD_C) begin
              r_state <= S_OFF;
              r_det   <= 1'b0;
              r_hc    <= '0;
            end else begin
              r_hc <= r_hc + 4'd1;
            end
          end else begin
            r_state <= S_ON;
            r_hc    <= '0;
          end
        end
        default: begin
          r_state <= S_OFF;
          r_det   <= 1'b0;
          r_hc    <= '0;
        end
      endcase
    end
  end

  assign energy       = r_energy;
  assign energy_valid = r_ev;
  assign detected     = r_det;

endmodule

// File: tb/tb_energy_detect.sv
// Directed checks of window summing, pulse timing, hold/hysteresis decisions and reset behaviour.
module tb_energy_detect;

  localparam int DW    = 16;
  localparam int LOG2W = 4;
  localparam int EW    = DW + LOG2W;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic signed [DW-1:0] x = '0;
  logic                 x_valid = 1'b0;
  logic [EW-1:0]        energy;
  logic                 energy_valid;
  logic                 detected;

  int n_checks = 0;
  int n_errors = 0;

  energy_detect #(
    .DW(DW), .LOG2W(LOG2W),
    .TH_ON(20'd16000), .TH_OFF(20'd8000), .HOLD(2)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid),
    .energy(energy), .energy_valid(energy_valid), .detected(detected)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic with_sample);
    rst     = 1'b1;
    x_valid = with_sample;
    x       = 16'sd1234;
    step();
    rst     = 1'b0;
    x_valid = 1'b0;
  endtask

  // Feed n samples (optionally alternating sign) with gap idle cycles between them.
  task automatic feed(input int v, input int n, input int gap, input bit alt);
    for (int i = 0; i < n; i++) begin
      x       = (alt && i[0]) ? DW'(-v) : DW'(v);
      x_valid = 1'b1;
      step();
      x_valid = 1'b0;
      if (i != n - 1) repeat (gap) step();
    end
  endtask

  // One full window, then check the pulse cycle and the following cycle.
  task automatic window(input string tag, input int v, input int gap, input bit alt,
                        input int exp_en, input bit det_before, input bit det_after);
    feed(v, 16, gap, alt);
    check({tag, "_energy"}, energy, exp_en);
    check({tag, "_ev_hi"}, energy_valid, 1);
    check({tag, "_det_pulse"}, detected, det_before);
    step();
    check({tag, "_ev_lo"}, energy_valid, 0);
    check({tag, "_det"}, detected, det_after);
    check({tag, "_hold"}, energy, exp_en);
  endtask

  initial begin
    step();
    do_reset(1'b1);
    check("rst_energy", energy, 0);
    check("rst_ev", energy_valid, 0);
    check("rst_det", detected, 0);

    // Steady +1000: arm on the first window, turn on after the second.
    window("w1k_a", 1000, 0, 1'b0, 16000, 1'b0, 1'b0);
    window("w1k_b", 1000, 0, 1'b0, 16000, 1'b0, 1'b1);

    // Alternating sign with sparse strobes gives the same magnitude sum.
    do_reset(1'b0);
    check("rst2_det", detected, 0);
    feed(1000, 8, 2, 1'b1);
    check("mid_ev", energy_valid, 0);
    check("mid_energy", energy, 0);
    feed(1000, 8, 2, 1'b1);
    check("alt_a_energy", energy, 16000);
    check("alt_a_ev", energy_valid, 1);
    step();
    check("alt_a_det", detected, 0);
    window("alt_b", 1000, 2, 1'b1, 16000, 1'b0, 1'b1);

    // Most negative sample, then hysteresis sequence from the on state.
    do_reset(1'b0);
    window("neg", -32768, 0, 1'b0, 524288, 1'b0, 1'b0);
    window("to_on", 1000, 0, 1'b0, 16000, 1'b0, 1'b1);
    window("w600", 600, 0, 1'b0, 9600, 1'b1, 1'b1);
    window("w400_a", 400, 0, 1'b0, 6400, 1'b1, 1'b1);
    window("w1k_re", 1000, 0, 1'b0, 16000, 1'b1, 1'b1);
    window("w400_b", 400, 0, 1'b0, 6400, 1'b1, 1'b1);
    window("w400_c", 400, 0, 1'b0, 6400, 1'b1, 1'b0);

    // A partial window is discarded by reset.
    do_reset(1'b0);
    feed(1000, 8, 0, 1'b0);
    check("part_ev", energy_valid, 0);
    do_reset(1'b1);
    check("part_rst_energy", energy, 0);
    window("w500", 500, 0, 1'b0, 8000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
